// File: rtl/fifo_byte_packer_pkg.sv
// Shared definitions for the byte FIFO and its read-side packer.
// The state encoding is also used by the write-side producer.
package fifo_byte_packer_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_RD_LAT = 1;
    localparam int FIFO_DEPTH  = 8;
    localparam int FIFO_AW     = 3;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } pack_state_e;

endpackage

// File: rtl/syn_fifo.sv
// Synchronous byte FIFO with a registered read port: data_o is valid one clock after a pop.
// Reset is synchronous and active-low.
module syn_fifo
    import fifo_byte_packer_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int AW     = FIFO_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic [DATA_W-1:0] r_data;
    logic              w_wr;
    logic              w_rd;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (r_wptr == r_rptr);
    assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_wr    = wr_en_i && !full_o;
    assign w_rd    = rd_en_i && !empty_o;
    assign data_o  = r_data;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_data <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_data <= r_mem[r_rptr[AW-1:0]];
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_byte_packer.sv
// Read-side consumer of syn_fifo: pops bytes and packs BYTES of them into one word,
// presented on a valid/ready port. A flush pulse emits whatever has been collected.
module fifo_byte_packer
    import fifo_byte_packer_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int BYTES  = 4,
    parameter int CNT_W  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fifo_empty_i,
    input  logic [DATA_W-1:0]         fifo_data_i,
    output logic                      fifo_rd_en_o,
    input  logic                      flush_i,
    output logic [DATA_W*BYTES-1:0]   word_o,
    output logic [CNT_W-1:0]          word_bytes_o,
    output logic                      word_valid_o,
    input  logic                      word_ready_i
);

    localparam logic [CNT_W:0]   LP_BYTES = (CNT_W+1)'(BYTES);
    localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(BYTES - 1);

    pack_state_e              r_state;
    pack_state_e              w_state_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_rd_pend;
    logic                     r_flush_pend;
    logic [DATA_W*BYTES-1:0]  r_word;

    logic                     w_fill;
    logic                     w_capture;
    logic                     w_full;
    logic                     w_flush_done;
    logic                     w_accept;
    logic                     w_room;
    logic                     w_rd_en;
    logic                     w_valid;
    logic [BYTES-1:0]         w_lane_en;

    assign w_fill       = (r_state == ST_FILL);
    assign w_capture    = w_fill && r_rd_pend;
    assign w_full       = w_capture && (r_cnt == LP_LAST);
    // Flush completes only after any in-flight byte has landed.
    assign w_flush_done = w_fill && r_flush_pend && !r_rd_pend;
    assign w_accept     = (r_state == ST_HOLD) && word_ready_i;
    assign w_room       = (({1'b0, r_cnt} + (CNT_W+1)'(r_rd_pend)) < LP_BYTES);

    always_comb begin
        w_lane_en = '0;
        for (int k = 0; k < BYTES; k++) begin
            w_lane_en[k] = w_capture && (r_cnt == CNT_W'(k));
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: begin
                if (w_full || (w_flush_done && (r_cnt != '0))) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (word_ready_i) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    // Output logic
    always_comb begin
        w_rd_en = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            ST_FILL: w_rd_en = !rst && !fifo_empty_i && !r_flush_pend && w_room;
            ST_HOLD: w_valid = 1'b1;
            default: begin
                w_rd_en = 1'b0;
                w_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_rd_pend    <= 1'b0;
            r_flush_pend <= 1'b0;
            r_word       <= '0;
        end else begin
            r_rd_pend <= w_rd_en;

            if (w_accept) begin
                r_cnt  <= '0;
                r_word <= '0;
            end else if (w_capture) begin
                r_cnt <= r_cnt + 1'b1;
                for (int k = 0; k < BYTES; k++) begin
                    if (w_lane_en[k]) begin
                        r_word[DATA_W*k +: DATA_W] <= fifo_data_i;
                    end
                end
            end

            // A word that fills in the flush cycle already carries everything collected.
            if (w_full || w_flush_done) begin
                r_flush_pend <= 1'b0;
            end else if (w_fill && flush_i) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    assign fifo_rd_en_o = w_rd_en;
    assign word_valid_o = w_valid;
    assign word_o       = r_word;
    assign word_bytes_o = w_valid ? r_cnt : '0;

endmodule
